// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the two-port RAM arbiter: FSM state encodings,
//   default geometry and the wait-counter sizing helper.
//   No ports (package).
package mem_arbiter_pkg;

  // Default RAM geometry: 512 bytes, two cycles of read latency.
  localparam int ADDR_WIDTH_DEFAULT = 9;
  localparam int RD_LAT_DEFAULT     = 2;

  // FSM state encodings. Plain constants keep the encoding fixed for
  // older tools and for anyone probing the state bits on a logic analyser.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_RWAIT = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  // The read wait counter is preloaded with rd_lat and counts down to
  // zero, so it needs enough bits to hold rd_lat itself.
  function automatic int wait_cnt_width(input int rd_lat);
    return (rd_lat < 1) ? 1 : $clog2(rd_lat + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2
//   Combinational winner select between two requesters.
//   Ports:
//     req0, req1  in   request lines of port 0 / port 1
//     owner       in   port granted most recently
//     lock_valid  in   owner asked to keep the grant at its last ACK
//     g           out  winning port (meaningful only when any_req=1)
//     any_req     out  at least one request is pending
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic owner,
  input  logic lock_valid,
  output logic g,
  output logic any_req
);

  logic owner_req;

  // A held lock only counts while the owner is actually requesting;
  // otherwise a lone request wins and a tie goes to the non-owner.
  always_comb begin
    owner_req = owner ? req1 : req0;
    any_req   = req0 | req1;
    if (lock_valid && owner_req) begin
      g = owner;
    end else if (req0 && req1) begin
      g = ~owner;
    end else begin
      g = req1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one byte-wide RAM port between port 0 (cpu) and port 1
//   (loader/DMA). One byte per req/ack handshake, round-robin arbitration,
//   with a per-port lock to keep ownership across multi-byte sequences.
//   Ports:
//     clk, reset            clock; asynchronous active-low reset
//     pN_req/we/addr/wdata  request, direction, address and write byte (N=0,1)
//     pN_lock               keep the grant for this port's next request
//     pN_ack                one-cycle completion pulse
//     pN_rdata              last read byte for the port
//     mem_raddr/mem_waddr   RAM read / write address
//     mem_data_in           RAM write data
//     mem_write             RAM write strobe (one cycle per write)
//     mem_data_out          RAM read data
//     owner                 port currently or last granted
//     busy                  high whenever a transaction is in flight
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int addr_width = ADDR_WIDTH_DEFAULT,
  parameter int RD_LAT     = RD_LAT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [addr_width-1:0] p0_addr,
  input  logic [7:0]            p0_wdata,
  input  logic                  p0_lock,
  output logic                  p0_ack,
  output logic [7:0]            p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [addr_width-1:0] p1_addr,
  input  logic [7:0]            p1_wdata,
  input  logic                  p1_lock,
  output logic                  p1_ack,
  output logic [7:0]            p1_rdata,
  output logic [addr_width-1:0] mem_raddr,
  output logic [addr_width-1:0] mem_waddr,
  output logic [7:0]            mem_data_in,
  output logic                  mem_write,
  input  logic [7:0]            mem_data_out,
  output logic                  owner,
  output logic                  busy
);

  localparam int CW = wait_cnt_width(RD_LAT);

  logic [1:0]            state;
  logic [CW-1:0]         wait_cnt;
  logic                  lock_valid;
  logic                  g;
  logic                  any_req;
  logic                  sel_we;
  logic [addr_width-1:0] sel_addr;
  logic [7:0]            sel_wdata;

  rr_pick2 u_pick (
    .req0       (p0_req),
    .req1       (p1_req),
    .owner      (owner),
    .lock_valid (lock_valid),
    .g          (g),
    .any_req    (any_req)
  );

  // Steer the winning port's request fields toward the grant registers.
  always_comb begin
    sel_we    = g ? p1_we    : p0_we;
    sel_addr  = g ? p1_addr  : p0_addr;
    sel_wdata = g ? p1_wdata : p0_wdata;
  end

  assign busy = (state != ST_IDLE);

  // Arbiter FSM and all registered outputs. Request fields are latched
  // only at the IDLE grant, so a master may change them freely afterwards.
  // Reads stay in RWAIT for RD_LAT+1 cycles: the address is first valid in
  // the cycle after the grant and the RAM needs RD_LAT more cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      owner       <= 1'b1;
      lock_valid  <= 1'b0;
      wait_cnt    <= '0;
      mem_raddr   <= '0;
      mem_waddr   <= '0;
      mem_data_in <= '0;
      mem_write   <= 1'b0;
      p0_ack      <= 1'b0;
      p1_ack      <= 1'b0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
    end else begin
      mem_write <= 1'b0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner       <= g;
            mem_raddr   <= sel_addr;
            mem_waddr   <= sel_addr;
            mem_data_in <= sel_wdata;
            mem_write   <= sel_we;
            wait_cnt    <= CW'(RD_LAT);
            state       <= sel_we ? ST_WRITE : ST_RWAIT;
          end
        end
        ST_WRITE: begin
          if (owner) p1_ack <= 1'b1;
          else       p0_ack <= 1'b1;
          state <= ST_ACK;
        end
        ST_RWAIT: begin
          if (wait_cnt == '0) begin
            if (owner) begin
              p1_rdata <= mem_data_out;
              p1_ack   <= 1'b1;
            end else begin
              p0_rdata <= mem_data_out;
              p0_ack   <= 1'b1;
            end
            state <= ST_ACK;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        ST_ACK: begin
          // The owner's lock level in its ACK cycle decides whether it may
          // keep the port at the next IDLE.
          lock_valid <= owner ? p1_lock : p0_lock;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter: directed vector table, reset and
//   multi-cycle sequences, and randomized two-master traffic compared
//   against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int AW = 9;
  localparam int RL = 2;

  typedef struct {
    int         port;
    logic       we;
    logic [8:0] addr;
    logic [7:0] wdata;
    int         expLat;
    logic [7:0] expRdata;
  } vec_t;

  typedef struct {
    logic       we;
    logic [8:0] addr;
    logic [7:0] wdata;
    logic       lock;
    int         gap;
  } op_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          p0_req = 0, p0_we = 0, p0_lock = 0;
  logic [AW-1:0] p0_addr = '0;
  logic [7:0]    p0_wdata = '0;
  logic          p1_req = 0, p1_we = 0, p1_lock = 0;
  logic [AW-1:0] p1_addr = '0;
  logic [7:0]    p1_wdata = '0;
  logic          p0_ack, p1_ack;
  logic [7:0]    p0_rdata, p1_rdata;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [7:0]    mem_data_in, mem_data_out;
  logic          mem_write, owner, busy;

  logic          loadRam = 1'b0;
  logic [7:0]    ram [0:511];
  logic [7:0]    pipe [0:RL-1];
  logic [7:0]    refMem [0:511];
  logic [7:0]    lastRd [2];

  int passes = 0;
  int checks = 0;
  op_t q0[$];
  op_t q1[$];
  int  ackOrder[$];
  int  wrCycles[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  mem_arbiter #(.addr_width(AW), .RD_LAT(RL)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_lock(p0_lock), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_data_in(mem_data_in),
    .mem_write(mem_write), .mem_data_out(mem_data_out),
    .owner(owner), .busy(busy)
  );

  function automatic logic [7:0] initByte(input int i);
    logic [8:0] a;
    a = i[8:0];
    if (a == 9'h010) return 8'h7E;
    return a[7:0] ^ 8'hC3;
  endfunction

  // RAM with RL-cycle read pipeline: data out reflects raddr RL cycles ago.
  always @(posedge clk) begin
    if (loadRam) begin
      for (int i = 0; i < 512; i++) ram[i] <= initByte(i);
    end else if (mem_write) begin
      ram[mem_waddr] <= mem_data_in;
    end
    pipe[0] <= ram[mem_raddr];
    for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_data_out = pipe[RL-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passes++;
  endtask

  task automatic applyStimulus(input int p, input logic req, input logic we,
                               input logic [8:0] addr, input logic [7:0] wdata, input logic lock);
    if (p == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_lock = lock;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_lock = lock;
    end
  endtask

  task automatic resetDut();
    reset = 1'b0;
    loadRam = 1'b1;
    applyStimulus(0, 0, 0, 9'h0, 8'h0, 0);
    applyStimulus(1, 0, 0, 9'h0, 8'h0, 0);
    tick();
    loadRam = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 512; i++) refMem[i] = initByte(i);
    lastRd[0] = 8'h00;
    lastRd[1] = 8'h00;
  endtask

  function automatic int qSize(input int p);
    return (p == 0) ? q0.size() : q1.size();
  endfunction

  function automatic op_t qHead(input int p);
    return (p == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qPop(input int p);
    if (p == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  // One isolated transaction from IDLE, checked against the table record.
  task automatic runVector(input int idx, input vec_t v);
    int ackAt, wrAt, wrCount, otherAckCnt;
    logic [8:0] wa;
    logic [7:0] wd, rd, otherRd;
    string tag;
    tag = $sformatf("vec%0d", idx);
    ackAt = -1; wrAt = -1; wrCount = 0; otherAckCnt = 0;
    wa = '0; wd = '0; rd = '0;
    applyStimulus(v.port, 1'b1, v.we, v.addr, v.wdata, 1'b0);
    for (int k = 1; k <= 12 && ackAt < 0; k++) begin
      tick();
      if (k == 1) checkOutput({tag, "_busy"}, busy, 1);
      if (mem_write) begin
        wrCount++;
        if (wrAt < 0) begin wrAt = k; wa = mem_waddr; wd = mem_data_in; end
      end
      if ((v.port == 0) ? p1_ack : p0_ack) otherAckCnt++;
      if ((v.port == 0) ? p0_ack : p1_ack) begin
        ackAt = k;
        rd = (v.port == 0) ? p0_rdata : p1_rdata;
        applyStimulus(v.port, 1'b0, 1'b0, 9'h0, 8'h0, 1'b0);
      end
    end
    applyStimulus(v.port, 1'b0, 1'b0, 9'h0, 8'h0, 1'b0);
    tick();
    if (mem_write) wrCount++;
    otherRd = (v.port == 0) ? p1_rdata : p0_rdata;
    checkOutput({tag, "_ack_latency"}, ackAt, v.expLat);
    checkOutput({tag, "_idle_after"}, busy, 0);
    checkOutput({tag, "_other_ack"}, otherAckCnt, 0);
    checkOutput({tag, "_write_count"}, wrCount, v.we ? 1 : 0);
    checkOutput({tag, "_other_rdata"}, otherRd, lastRd[1 - v.port]);
    if (v.we) begin
      checkOutput({tag, "_write_cycle"}, wrAt, 1);
      checkOutput({tag, "_waddr"}, wa, v.addr);
      checkOutput({tag, "_wdata"}, wd, v.wdata);
    end else begin
      checkOutput({tag, "_rdata"}, rd, v.expRdata);
      checkOutput({tag, "_raddr"}, mem_raddr, v.addr);
      lastRd[v.port] = v.expRdata;
    end
  endtask

  // Two queue-driven masters plus a transaction-level model: at each
  // arbitration sample the model applies the grant rules to the requests
  // being driven, then predicts write strobe, ack cycle and read data.
  task automatic runTraffic(input int maxCycles, input string tag, input bit randIdleLock);
    logic       active [2];
    int         waitCnt [2];
    op_t        cur [2];
    int         mAck [2];
    logic [7:0] mRd [2];
    logic       mOwner, mLockValid, r0, r1, actAck, idleLock;
    int         nextSample, mWr, g;
    logic [8:0] mWa;
    logic [7:0] mWd;
    bit         done;
    op_t        h;
    ackOrder.delete();
    wrCycles.delete();
    mOwner = 1'b1; mLockValid = 1'b0; nextSample = 0; mWr = -1;
    mWa = '0; mWd = '0; done = 0;
    for (int p = 0; p < 2; p++) begin
      active[p] = 0; mAck[p] = -1; mRd[p] = 8'h00; waitCnt[p] = 0;
      cur[p] = '{1'b0, 9'h0, 8'h0, 1'b0, 0};
      if (qSize(p) > 0) begin h = qHead(p); waitCnt[p] = h.gap; end
    end
    for (int c = 0; c < maxCycles && !done; c++) begin
      if (c > 0) tick();
      for (int p = 0; p < 2; p++) begin
        actAck = (p == 0) ? p0_ack : p1_ack;
        checkOutput($sformatf("%s_ack%0d_c%0d", tag, p, c), actAck, (mAck[p] == c));
        if (mAck[p] == c) begin
          checkOutput($sformatf("%s_owner_c%0d", tag, c), owner, p);
          if (!cur[p].we)
            checkOutput($sformatf("%s_rdata%0d_c%0d", tag, p, c),
                        (p == 0) ? p0_rdata : p1_rdata, mRd[p]);
        end
      end
      checkOutput($sformatf("%s_mem_write_c%0d", tag, c), mem_write, (c == mWr));
      if (mem_write) wrCycles.push_back(c);
      if (c == mWr) begin
        checkOutput($sformatf("%s_waddr_c%0d", tag, c), mem_waddr, mWa);
        checkOutput($sformatf("%s_wdata_c%0d", tag, c), mem_data_in, mWd);
      end
      for (int p = 0; p < 2; p++) begin
        actAck = (p == 0) ? p0_ack : p1_ack;
        if (actAck && active[p]) begin
          ackOrder.push_back(p);
          qPop(p);
          active[p] = 0;
          waitCnt[p] = 0;
          if (qSize(p) > 0) begin h = qHead(p); waitCnt[p] = h.gap; end
          idleLock = randIdleLock ? 1'($urandom_range(0, 1)) : 1'b0;
          applyStimulus(p, 1'b0, 1'b0, 9'h0, 8'h0, idleLock);
        end
        if (!active[p]) begin
          if (qSize(p) > 0 && waitCnt[p] == 0) begin
            h = qHead(p);
            cur[p] = h;
            active[p] = 1;
            applyStimulus(p, 1'b1, h.we, h.addr, h.wdata, h.lock);
          end else if (waitCnt[p] > 0) begin
            waitCnt[p]--;
          end
        end
      end
      if (c == mAck[mOwner]) mLockValid = mOwner ? p1_lock : p0_lock;
      if (c == nextSample) begin
        r0 = p0_req;
        r1 = p1_req;
        if (!r0 && !r1) begin
          nextSample = c + 1;
        end else begin
          if (mLockValid && (mOwner ? r1 : r0)) g = int'(mOwner);
          else if (r0 && r1)                    g = mOwner ? 0 : 1;
          else                                  g = r1 ? 1 : 0;
          mOwner = g[0];
          h = cur[g];
          if (h.we) begin
            mWr = c + 1; mWa = h.addr; mWd = h.wdata;
            refMem[h.addr] = h.wdata;
            mAck[g] = c + 2;
            nextSample = c + 3;
          end else begin
            mRd[g] = refMem[h.addr];
            mAck[g] = c + RL + 2;
            nextSample = c + RL + 3;
          end
        end
      end
      done = (qSize(0) == 0) && (qSize(1) == 0) && !active[0] && !active[1] &&
             (mAck[0] < c) && (mAck[1] < c) && (mWr < c);
    end
    checkOutput({tag, "_drained"}, done, 1);
  endtask

  function automatic int orderAt(input int i);
    return (i < ackOrder.size()) ? ackOrder[i] : 99;
  endfunction

  initial begin
    resetDut();

    // Reset state.
    checkOutput("rst_owner", owner, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_write", mem_write, 0);
    checkOutput("rst_p0_rdata", p0_rdata, 0);
    checkOutput("rst_p1_rdata", p1_rdata, 0);
    checkOutput("rst_raddr", mem_raddr, 0);
    checkOutput("rst_data_in", mem_data_in, 0);

    // Directed single transactions.
    vecs[0] = '{0, 1'b1, 9'h1A5, 8'h3C, 2, 8'h00};
    vecs[1] = '{1, 1'b0, 9'h010, 8'h00, 4, 8'h7E};
    vecs[2] = '{1, 1'b1, 9'h0FF, 8'hA5, 2, 8'h00};
    vecs[3] = '{0, 1'b0, 9'h0FF, 8'h00, 4, 8'hA5};
    vecs[4] = '{1, 1'b0, 9'h1A5, 8'h00, 4, 8'h3C};
    vecs[5] = '{0, 1'b0, 9'h133, 8'h00, 4, 8'hF0};
    for (int i = 0; i < 6; i++) runVector(i, vecs[i]);

    // Async reset in the middle of a read.
    applyStimulus(1, 1'b1, 1'b0, 9'h020, 8'h00, 1'b0);
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    checkOutput("rwait_rst_busy", busy, 0);
    checkOutput("rwait_rst_p1_ack", p1_ack, 0);
    checkOutput("rwait_rst_mem_write", mem_write, 0);
    checkOutput("rwait_rst_raddr", mem_raddr, 0);
    checkOutput("rwait_rst_p0_rdata", p0_rdata, 0);
    applyStimulus(1, 1'b0, 1'b0, 9'h0, 8'h0, 1'b0);
    tick();
    tick();
    reset = 1'b1;

    // Async reset during the write strobe: strobe drops, no ack follows.
    applyStimulus(0, 1'b1, 1'b1, 9'h055, 8'h99, 1'b0);
    tick();
    checkOutput("wr_rst_strobe_before", mem_write, 1);
    checkOutput("wr_rst_owner_before", owner, 0);
    #2 reset = 1'b0;
    #1;
    checkOutput("wr_rst_strobe_dropped", mem_write, 0);
    applyStimulus(0, 1'b0, 1'b0, 9'h0, 8'h0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("wr_rst_owner_after", owner, 1);
    checkOutput("wr_rst_no_ack", p0_ack, 0);
    checkOutput("wr_rst_busy", busy, 0);
    tick();
    checkOutput("wr_rst_ram_untouched", ram[9'h055], initByte(9'h055));

    // Both ports reading continuously from reset: strict alternation.
    resetDut();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'b0, 9'(9'h010 + i), 8'h00, 1'b0, 0});
      q1.push_back('{1'b0, 9'(9'h1A0 + i), 8'h00, 1'b0, 0});
    end
    runTraffic(200, "alt", 1'b0);
    checkOutput("alt_count", ackOrder.size(), 8);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("alt_order%0d", i), orderAt(i), i % 2);

    // Port 0 locks for four writes while port 1 waits.
    resetDut();
    for (int i = 0; i < 4; i++) q0.push_back('{1'b1, 9'(9'h040 + i), 8'(8'h50 + i), 1'b1, 0});
    q1.push_back('{1'b0, 9'h041, 8'h00, 1'b0, 0});
    runTraffic(200, "lock", 1'b0);
    checkOutput("lock_count", ackOrder.size(), 5);
    for (int i = 0; i < 5; i++) checkOutput($sformatf("lock_order%0d", i), orderAt(i), (i < 4) ? 0 : 1);

    // Back-to-back writes with req held through ACK.
    resetDut();
    for (int i = 0; i < 4; i++) q0.push_back('{1'b1, 9'(9'h100 + i), 8'(8'hE0 + i), 1'b0, 0});
    runTraffic(200, "b2b", 1'b0);
    checkOutput("b2b_write_pulses", wrCycles.size(), 4);
    for (int i = 1; i < wrCycles.size(); i++)
      checkOutput($sformatf("b2b_spacing%0d", i), wrCycles[i] - wrCycles[i-1], 3);

    // Randomized traffic from both masters.
    resetDut();
    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < 2; p++) begin
        op_t o;
        o.we    = 1'($urandom_range(0, 1));
        o.addr  = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 7));
        o.wdata = 8'($urandom);
        o.lock  = ($urandom_range(0, 3) == 0);
        o.gap   = $urandom_range(0, 3);
        if (p == 0) q0.push_back(o);
        else        q1.push_back(o);
      end
    end
    runTraffic(3000, "rand", 1'b1);
    checkOutput("rand_acks", ackOrder.size(), 80);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
